// File: rtl/clock_div_switch.sv
// NUM_CH programmable clock dividers with a glitch-free handshaked channel switch
// whose selected tick advances a DEPTH-stage data pipeline. Optional: CDS_TICK_CNT_EN.
module clock_div_switch #(
    parameter int NUM_CH = 3,
    parameter int DIV_W  = 8,
    parameter int SEL_W  = 2,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    input  logic                    cfg_load,
    input  logic                    sel_req_valid,
    input  logic [SEL_W-1:0]        sel_req,
    output logic                    sel_req_ready,
    output logic                    sel_err,
    output logic [SEL_W-1:0]        sel_cur,
    output logic [NUM_CH-1:0]       div_clk,
    output logic [NUM_CH-1:0]       div_tick,
    output logic                    sel_clk,
    input  logic [DATA_W-1:0]       data_in,
    output logic [DATA_W-1:0]       data_out,
    output logic                    data_valid
`ifdef CDS_TICK_CNT_EN
    ,
    output logic [NUM_CH*16-1:0]    tick_cnt
`endif
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_PARK  = 2'd2;
    localparam logic [SEL_W:0] NUM_CH_W = (SEL_W+1)'(NUM_CH);

    logic [NUM_CH-1:0] div_clk_q, div_clk_d;
    logic [NUM_CH-1:0] div_tick_q, div_tick_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] ratio_q, ratio_d;
            logic [DIV_W-1:0] cnt_q, cnt_d;
            logic             active_d;

            // Outputs are derived from the next count so they register alongside it.
            always_comb begin
                ratio_d = ratio_q;
                cnt_d   = cnt_q;
                if (cfg_load) begin
                    ratio_d = div_ratio[gi*DIV_W +: DIV_W];
                    cnt_d   = '0;
                end else if (ratio_q < DIV_W'(2)) begin
                    cnt_d = '0;
                end else if (cnt_q == ratio_q - DIV_W'(1)) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
                active_d = (ratio_d >= DIV_W'(2));
            end

            assign div_clk_d[gi]  = active_d && (cnt_d < (ratio_d >> 1));
            assign div_tick_d[gi] = active_d && (cnt_d == '0);

            always_ff @(posedge clk_in or negedge rst_n) begin
                if (!rst_n) begin
                    ratio_q <= '0;
                    cnt_q   <= '0;
                end else begin
                    ratio_q <= ratio_d;
                    cnt_q   <= cnt_d;
                end
            end

`ifdef CDS_TICK_CNT_EN
            logic [15:0] tcnt_q, tcnt_d;
            always_comb begin
                tcnt_d = tcnt_q;
                if (cfg_load)
                    tcnt_d = '0;
                else if (div_tick_q[gi])
                    tcnt_d = tcnt_q + 16'd1;
            end
            always_ff @(posedge clk_in or negedge rst_n) begin
                if (!rst_n) tcnt_q <= '0;
                else        tcnt_q <= tcnt_d;
            end
            assign tick_cnt[gi*16 +: 16] = tcnt_q;
`endif
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_cur_q, sel_cur_d;
    logic [SEL_W-1:0] target_q, target_d;
    logic             sel_err_q, sel_err_d;
    logic             sel_clk_q, sel_clk_d;
    logic             sel_tick;

    always_comb begin
        state_d   = state_q;
        sel_cur_d = sel_cur_q;
        target_d  = target_q;
        sel_err_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (sel_req_valid) begin
                    if ({1'b0, sel_req} >= NUM_CH_W) begin
                        sel_err_d = 1'b1;
                    end else if (sel_req != sel_cur_q) begin
                        target_d = sel_req;
                        state_d  = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!div_clk_q[sel_cur_q])
                    state_d = ST_PARK;
            end
            ST_PARK: begin
                if (!div_clk_q[target_q]) begin
                    sel_cur_d = target_q;
                    state_d   = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        // Output stays low while parked, so neither channel's phase gets clipped.
        sel_clk_d = (state_q != ST_PARK) && div_clk_q[sel_cur_q];
        sel_tick  = (state_q != ST_PARK) && div_tick_q[sel_cur_q];
    end

    logic [DATA_W-1:0] stage_q [DEPTH];
    logic [DATA_W-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) stage_d[k] = stage_q[k];
        valid_d = valid_q;
        if (sel_tick) begin
            stage_d[0] = data_in;
            valid_d[0] = 1'b1;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
                valid_d[k] = valid_q[k-1];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            div_clk_q  <= '0;
            div_tick_q <= '0;
            state_q    <= ST_RUN;
            sel_cur_q  <= '0;
            target_q   <= '0;
            sel_err_q  <= 1'b0;
            sel_clk_q  <= 1'b0;
            valid_q    <= '0;
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
        end else begin
            div_clk_q  <= div_clk_d;
            div_tick_q <= div_tick_d;
            state_q    <= state_d;
            sel_cur_q  <= sel_cur_d;
            target_q   <= target_d;
            sel_err_q  <= sel_err_d;
            sel_clk_q  <= sel_clk_d;
            valid_q    <= valid_d;
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
        end
    end

    assign sel_req_ready = (state_q == ST_RUN);
    assign sel_err       = sel_err_q;
    assign sel_cur       = sel_cur_q;
    assign div_clk       = div_clk_q;
    assign div_tick      = div_tick_q;
    assign sel_clk       = sel_clk_q;
    assign data_out      = stage_q[DEPTH-1];
    assign data_valid    = valid_q[DEPTH-1];

endmodule

// File: tb/tb_clock_div_switch.sv
// Directed bench for clock_div_switch: divider waveforms, pipeline latency,
// channel switch sequencing, range errors and asynchronous reset.
module tb_clock_div_switch;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 8;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic                    clk_in = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_CH*DIV_W-1:0] div_ratio = '0;
    logic                    cfg_load = 1'b0;
    logic                    sel_req_valid = 1'b0;
    logic [SEL_W-1:0]        sel_req = '0;
    logic                    sel_req_ready;
    logic                    sel_err;
    logic [SEL_W-1:0]        sel_cur;
    logic [NUM_CH-1:0]       div_clk;
    logic [NUM_CH-1:0]       div_tick;
    logic                    sel_clk;
    logic [DATA_W-1:0]       data_in = '0;
    logic [DATA_W-1:0]       data_out;
    logic                    data_valid;

    clock_div_switch #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .SEL_W(SEL_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .div_ratio(div_ratio), .cfg_load(cfg_load),
        .sel_req_valid(sel_req_valid), .sel_req(sel_req), .sel_req_ready(sel_req_ready),
        .sel_err(sel_err), .sel_cur(sel_cur), .div_clk(div_clk), .div_tick(div_tick),
        .sel_clk(sel_clk), .data_in(data_in), .data_out(data_out), .data_valid(data_valid)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cfg_load = 1'b0;
        sel_req_valid = 1'b0;
        sel_req = '0;
        data_in = '0;
        div_ratio = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic wait_tick(input int ch, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (div_tick[ch]) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    // Hand-derived waveforms for ratios {5,3,2}, cycle 0 = first cycle after cfg_load
    logic [2:0] exp_clk2 [10] = '{3'b111, 3'b100, 3'b001, 3'b010, 3'b001,
                                  3'b100, 3'b111, 3'b000, 3'b001, 3'b010};
    logic [2:0] exp_tck2 [10] = '{3'b111, 3'b000, 3'b001, 3'b010, 3'b001,
                                  3'b100, 3'b011, 3'b000, 3'b001, 3'b010};
    // Switch 0->2 with ratios {8,-,4}, request presented in cycle 0
    logic       exp_sc4  [14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       exp_rdy4 [6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] vals3    [5]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    initial begin
        logic [3:0] acc;
        bit ok;

        // 1: idle after reset
        do_reset();
        acc = '0;
        for (int i = 0; i < 100; i++) begin
            acc = acc | {div_clk[0] | div_clk[1] | div_clk[2],
                         div_tick[0] | div_tick[1] | div_tick[2], sel_clk, data_valid};
            cyc();
        end
        check_val("t1_idle_activity", {28'd0, acc}, 32'd0);
        check_val("t1_sel_cur", {30'd0, sel_cur}, 32'd0);
        check_val("t1_ready", {31'd0, sel_req_ready}, 32'd1);
        check_val("t1_sel_err", {31'd0, sel_err}, 32'd0);
        check_val("t1_data_out", {24'd0, data_out}, 32'd0);

        // 2: divider waveforms
        div_ratio = {8'd5, 8'd3, 8'd2};
        cfg_load = 1'b1;
        cyc();
        cfg_load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            $display("t2 cycle %0d: div_clk=%b div_tick=%b sel_clk=%b", i, div_clk, div_tick, sel_clk);
            check_val($sformatf("t2_div_clk_c%0d", i), {29'd0, div_clk}, {29'd0, exp_clk2[i]});
            check_val($sformatf("t2_div_tick_c%0d", i), {29'd0, div_tick}, {29'd0, exp_tck2[i]});
            check_val($sformatf("t2_sel_clk_c%0d", i), {31'd0, sel_clk}, {31'd0, i[0]});
            cyc();
        end

        // 3: pipeline latency on ch0 N=4
        do_reset();
        div_ratio = {8'd0, 8'd0, 8'd4};
        cfg_load = 1'b1;
        cyc();
        cfg_load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_tick(0, ok);
            check_val($sformatf("t3_tick_seen_%0d", i), {31'd0, ok}, 32'd1);
            if (i == 3) check_val("t3_valid_before_4th", {31'd0, data_valid}, 32'd0);
            data_in = vals3[i];
            cyc();
            $display("t3 tick %0d: data_in=%h data_out=%h data_valid=%b", i, vals3[i], data_out, data_valid);
            if (i == 3) begin
                check_val("t3_data_out_4th", {24'd0, data_out}, 32'h11);
                check_val("t3_valid_4th", {31'd0, data_valid}, 32'd1);
            end
        end
        check_val("t3_data_out_5th", {24'd0, data_out}, 32'h22);

        // 4: switch 0 -> 2 while div_clk[0] high
        do_reset();
        div_ratio = {8'd8, 8'd0, 8'd4};
        cfg_load = 1'b1;
        cyc();
        cfg_load = 1'b0;
        check_val("t4_ch0_high_at_req", {31'd0, div_clk[0]}, 32'd1);
        for (int i = 0; i < 14; i++) begin
            $display("t4 cycle %0d: ready=%b sel_clk=%b sel_cur=%0d", i, sel_req_ready, sel_clk, sel_cur);
            check_val($sformatf("t4_sel_clk_c%0d", i), {31'd0, sel_clk}, {31'd0, exp_sc4[i]});
            if (i < 6)
                check_val($sformatf("t4_ready_c%0d", i), {31'd0, sel_req_ready}, {31'd0, exp_rdy4[i]});
            if (i == 4) check_val("t4_sel_cur_before", {30'd0, sel_cur}, 32'd0);
            if (i == 0) begin
                sel_req_valid = 1'b1;
                sel_req = 2'd2;
            end else begin
                sel_req_valid = 1'b0;
            end
            cyc();
        end
        check_val("t4_sel_cur_after", {30'd0, sel_cur}, 32'd2);

        // 5: out-of-range and same-channel requests
        sel_req_valid = 1'b1;
        sel_req = 2'd3;
        check_val("t5_ready_oor", {31'd0, sel_req_ready}, 32'd1);
        cyc();
        sel_req_valid = 1'b0;
        $display("t5 req=3: sel_err=%b sel_cur=%0d ready=%b", sel_err, sel_cur, sel_req_ready);
        check_val("t5_err_pulse", {31'd0, sel_err}, 32'd1);
        check_val("t5_sel_cur_kept", {30'd0, sel_cur}, 32'd2);
        check_val("t5_ready_after", {31'd0, sel_req_ready}, 32'd1);
        cyc();
        check_val("t5_err_once", {31'd0, sel_err}, 32'd0);
        sel_req_valid = 1'b1;
        sel_req = 2'd2;
        cyc();
        sel_req_valid = 1'b0;
        $display("t5 req=2 (same): sel_err=%b sel_cur=%0d ready=%b", sel_err, sel_cur, sel_req_ready);
        check_val("t5_same_ready", {31'd0, sel_req_ready}, 32'd1);
        check_val("t5_same_err", {31'd0, sel_err}, 32'd0);
        check_val("t5_same_sel_cur", {30'd0, sel_cur}, 32'd2);

        // 6: asynchronous reset while parked
        do_reset();
        div_ratio = {8'd8, 8'd0, 8'd4};
        data_in = 8'hAB;
        cfg_load = 1'b1;
        cyc();
        cfg_load = 1'b0;
        for (int i = 0; i < 16; i++) cyc();
        check_val("t6_pipe_full_valid", {31'd0, data_valid}, 32'd1);
        check_val("t6_pipe_full_data", {24'd0, data_out}, 32'hAB);
        check_val("t6_clks_high_at_req", {29'd0, div_clk}, 32'b101);
        sel_req_valid = 1'b1;
        sel_req = 2'd2;
        cyc();
        sel_req_valid = 1'b0;
        cyc();
        cyc();
        check_val("t6_parked_ready", {31'd0, sel_req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        $display("t6 async reset: ready=%b sel_clk=%b sel_cur=%0d data_out=%h data_valid=%b",
                 sel_req_ready, sel_clk, sel_cur, data_out, data_valid);
        check_val("t6_rst_ready", {31'd0, sel_req_ready}, 32'd1);
        check_val("t6_rst_sel_clk", {31'd0, sel_clk}, 32'd0);
        check_val("t6_rst_sel_cur", {30'd0, sel_cur}, 32'd0);
        check_val("t6_rst_data_out", {24'd0, data_out}, 32'd0);
        check_val("t6_rst_data_valid", {31'd0, data_valid}, 32'd0);
        check_val("t6_rst_div_clk", {29'd0, div_clk}, 32'd0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        check_val("t6_target_dropped", {30'd0, sel_cur}, 32'd0);
        check_val("t6_ready_after", {31'd0, sel_req_ready}, 32'd1);
        check_val("t6_still_idle", {29'd0, div_clk}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
